// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM with a tagged single-outstanding request and an in-order instruction buffer.
// Macro FETCH_SKID_BUF_EN selects a 2-entry buffer (skid for one decode stall cycle); undefined gives 1 entry.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    output logic [31:0] pc_next,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

`ifdef FETCH_SKID_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic [CNT_W-1:0] occ_s;
    logic [63:0]      buf_r [DEPTH];
    logic [63:0]      buf_s [DEPTH];
    logic [31:0]      tag_r;
    logic             discard_r;
    logic             discard_s;
    logic             start_r;
    logic             imem_req_r;
    logic             imem_req_s;
    logic             valid_r;
    logic             grant_s;
    logic             push_s;
    logic             pop_s;
    logic             room_s;
    logic             room_after_push_s;

    assign imem_req    = imem_req_r;
    assign imem_addr   = pc;
    assign instr_valid = valid_r;
    assign instr       = buf_r[0][63:32];
    assign instr_pc    = buf_r[0][31:0];

    // Handshake qualifiers and slot accounting (occ_s = entries left once this cycle's pop is taken).
    always_comb begin
        grant_s           = (state_r == REQ) && imem_gnt;
        pop_s             = valid_r && instr_ready;
        push_s            = (state_r == WAIT) && imem_rvalid && !redirect;
        occ_s             = count_r - {1'b0, pop_s};
        room_s            = occ_s < DEPTH_C;
        room_after_push_s = (occ_s + 2'd1) < DEPTH_C;
    end

    // FSM state register; start_r holds off the first request for one cycle after reset release.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            start_r <= 1'b1;
        end else begin
            state_r <= state_s;
            start_r <= 1'b0;
        end
    end

    // FSM next-state logic; a pending discarded response blocks new requests.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!redirect && !discard_r && !start_r && room_s) state_s = REQ;
                else                                               state_s = IDLE;
            end
            REQ: begin
                if (redirect)      state_s = IDLE;
                else if (imem_gnt) state_s = WAIT;
                else               state_s = REQ;
            end
            WAIT: begin
                if (redirect)          state_s = IDLE;
                else if (imem_rvalid)  state_s = room_after_push_s ? REQ : IDLE;
                else                   state_s = WAIT;
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM output logic: request strobe is registered from the next state.
    always_comb begin
        if (state_s == REQ) imem_req_s = 1'b1;
        else                imem_req_s = 1'b0;
    end

    // Next PC: redirect beats the grant increment; reset and the first cycle after it drive RESET_PC.
    always_comb begin
        if (start_r)       pc_next = RESET_PC;
        else if (redirect) pc_next = redirect_target;
        else if (grant_s)  pc_next = pc + 32'd4;
        else               pc_next = pc;
    end

    // Discard flag tracks a response that must be dropped because a redirect overtook it.
    always_comb begin
        if (redirect)         discard_s = ((state_r == WAIT) && !imem_rvalid) || grant_s || (discard_r && !imem_rvalid);
        else if (imem_rvalid) discard_s = 1'b0;
        else                  discard_s = discard_r;
    end

    // Buffer next state: shift on pop, write behind the surviving entries on push, flush on redirect.
    always_comb begin
        if (redirect) count_s = {CNT_W{1'b0}};
        else          count_s = count_r + {1'b0, push_s} - {1'b0, pop_s};
        for (int i = 0; i < DEPTH; i++) begin
            if (push_s && (occ_s == CNT_W'(i))) buf_s[i] = {imem_rdata, tag_r};
            else if (pop_s)                     buf_s[i] = buf_r[(i + 1) % DEPTH];
            else                                buf_s[i] = buf_r[i];
        end
    end

    // Buffer, tag, discard and registered output flops.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r    <= {CNT_W{1'b0}};
            tag_r      <= 32'h0000_0000;
            discard_r  <= 1'b0;
            imem_req_r <= 1'b0;
            valid_r    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) buf_r[i] <= 64'h0;
        end else begin
            count_r    <= count_s;
            discard_r  <= discard_s;
            imem_req_r <= imem_req_s;
            valid_r    <= (count_s != {CNT_W{1'b0}});
            if (grant_s) tag_r <= pc;
            for (int i = 0; i < DEPTH; i++) buf_r[i] <= buf_s[i];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed phases push expected {instr, pc} into a scoreboard queue;
// a monitor pops and compares on every decode accept. Memory returns addr ^ 32'hDEAD_BEEF.
module tb_fetch_unit;

`ifdef FETCH_SKID_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [31:0] KEY = 32'hDEAD_BEEF;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc_reg = 32'h0;
    logic [31:0] pc_next;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int          vectors  = 0;
    int          errors   = 0;
    int          lat      = 1;
    int          hs_total = 0;
    int          hs0;
    logic [63:0] exp_q[$];

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .pc             (pc_reg),
        .pc_next        (pc_next),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    always #5 clock = ~clock;

    // External PC register.
    always @(posedge clock) pc_reg <= pc_next;

    always @(negedge clock) if (imem_req && imem_gnt) hs_total <= hs_total + 1;

    // Memory: one outstanding access, response lat cycles after grant.
    initial begin : mem_model
        logic [31:0] a;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clock);
            if (imem_req && imem_gnt) begin
                a = imem_addr;
                repeat (lat) @(posedge clock);
                #1;
                imem_rvalid = 1'b1;
                imem_rdata  = a ^ KEY;
                @(posedge clock);
                #1;
                imem_rvalid = 1'b0;
            end
        end
    end

    // Scoreboard monitor.
    initial begin : monitor
        logic [63:0] e;
        forever begin
            @(negedge clock);
            if (reset && instr_valid && instr_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected got pc=%h instr=%h want no entry", instr_pc, instr);
                end else begin
                    e = exp_q.pop_front();
                    if ({instr, instr_pc} !== e) begin
                        errors++;
                        $display("FAIL pop got pc=%h instr=%h want pc=%h instr=%h", instr_pc, instr, e[31:0], e[63:32]);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_hs(input logic [31:0] addr, input string name);
        bit found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clock);
            if (imem_req && imem_gnt && imem_addr == addr) found = 1'b1;
        end
        vectors++;
        if (!found) begin
            errors++;
            $display("FAIL %s got no grant want grant at %h", name, addr);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s got %0d pending want 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin : stim
        reset = 1'b0; redirect = 1'b0; redirect_target = 32'h0;
        imem_gnt = 1'b0; instr_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_req",     {31'h0, imem_req},    32'h0);
        check("rst_valid",   {31'h0, instr_valid}, 32'h0);
        check("rst_instr",   instr,                32'h0);
        check("rst_instrpc", instr_pc,             32'h0);
        check("rst_pcnext",  pc_next,              32'h0);
        @(posedge clock);
        #1;
        reset = 1'b1; imem_gnt = 1'b1;
        @(negedge clock);
        check("start_req0", {31'h0, imem_req}, 32'h0);
        @(negedge clock);
        check("start_req1", {31'h0, imem_req}, 32'h0);

        // Streaming fetch 0, 4, 8.
        exp_q.push_back({32'hDEAD_BEEF, 32'h0000_0000});
        exp_q.push_back({32'hDEAD_BEEB, 32'h0000_0004});
        exp_q.push_back({32'hDEAD_BEE7, 32'h0000_0008});
        wait_hs(32'h0, "hs_0");
        wait_hs(32'h4, "hs_4");
        wait_hs(32'h8, "hs_8");
        step(); imem_gnt = 1'b0;
        wait_drain("drain_stream");

        // Decode stall: buffer fills to DEPTH, then requests stop; order kept on release.
        step(); instr_ready = 1'b0; imem_gnt = 1'b1; hs0 = hs_total;
        exp_q.push_back({32'hDEAD_BEE3, 32'h0000_000C});
        if (DEPTH == 2) exp_q.push_back({32'hDEAD_BEFF, 32'h0000_0010});
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (k == 2) check("stall_pc_early", instr_pc, 32'h0000_000C);
        end
        check("stall_pc_late", instr_pc, 32'h0000_000C);
        check("stall_instr",   instr,    32'hDEAD_BEE3);
        check("stall_valid",   {31'h0, instr_valid}, 32'h1);
        check("stall_req",     {31'h0, imem_req},    32'h0);
        check("stall_hs",      hs_total - hs0,       DEPTH);
        step(); instr_ready = 1'b1; imem_gnt = 1'b0;
        wait_drain("drain_stall");

        // Redirect while waiting on 0x8: response dropped, fetch resumes at 0x100.
        step(); redirect = 1'b1; redirect_target = 32'h0000_0008;
        @(negedge clock);
        check("redir8_pcnext", pc_next, 32'h0000_0008);
        step(); redirect = 1'b0; lat = 3; imem_gnt = 1'b1;
        exp_q.push_back({32'hDEAD_BFEF, 32'h0000_0100});
        wait_hs(32'h8, "hs_8_wait");
        step(); redirect = 1'b1; redirect_target = 32'h0000_0100;
        @(negedge clock);
        check("redir100_pcnext", pc_next, 32'h0000_0100);
        step(); redirect = 1'b0;
        @(negedge clock);
        check("redir100_valid", {31'h0, instr_valid}, 32'h0);
        wait_hs(32'h100, "hs_100");
        step(); imem_gnt = 1'b0;
        wait_drain("drain_redirect");

        // Redirect coinciding with rvalid of 0x104: no push, pc_next takes the target.
        step(); lat = 1; imem_gnt = 1'b1;
        exp_q.push_back({32'hDEAD_BCEF, 32'h0000_0200});
        wait_hs(32'h104, "hs_104");
        step(); redirect = 1'b1; redirect_target = 32'h0000_0200;
        @(negedge clock);
        check("rv_redir_pcnext", pc_next, 32'h0000_0200);
        step(); redirect = 1'b0;
        @(negedge clock);
        check("rv_redir_nopush", {31'h0, instr_valid}, 32'h0);
        wait_hs(32'h200, "hs_200");
        step(); imem_gnt = 1'b0;
        wait_drain("drain_rv_redir");

        // PC wrap at the top of the address space.
        step(); redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
        @(negedge clock);
        check("wrap_redir_pcnext", pc_next, 32'hFFFF_FFFC);
        step(); redirect = 1'b0; imem_gnt = 1'b1;
        exp_q.push_back({32'h2152_4113, 32'hFFFF_FFFC});
        exp_q.push_back({32'hDEAD_BEEF, 32'h0000_0000});
        wait_hs(32'hFFFF_FFFC, "hs_top");
        check("wrap_pcnext", pc_next, 32'h0000_0000);
        wait_hs(32'h0, "hs_wrapped");
        step(); imem_gnt = 1'b0;
        wait_drain("drain_wrap");

        // Reset during WAIT: immediate reset outputs, late response ignored.
        step(); lat = 4; imem_gnt = 1'b1;
        wait_hs(32'h4, "hs_4_rst");
        step(); imem_gnt = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_req",     {31'h0, imem_req},    32'h0);
        check("mid_rst_valid",   {31'h0, instr_valid}, 32'h0);
        check("mid_rst_instr",   instr,                32'h0);
        check("mid_rst_instrpc", instr_pc,             32'h0);
        check("mid_rst_pcnext",  pc_next,              32'h0);
        step(); reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            check("late_rvalid_valid", {31'h0, instr_valid}, 32'h0);
        end
        step(); lat = 1; imem_gnt = 1'b1;
        exp_q.push_back({32'hDEAD_BEEF, 32'h0000_0000});
        wait_hs(32'h0, "hs_after_rst");
        step(); imem_gnt = 1'b0;
        wait_drain("drain_after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the pc_next value driven during and immediately after reset.
REQ-002 clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 pc  input  32  SHALL be the current PC from the PC register; it is the fetch address.
REQ-005 pc_next  output  32  SHALL be the next PC, fed to the PC register input every cycle.
REQ-006 redirect  input  1  SHALL be a branch/jump redirect strobe, one cycle.
REQ-007 redirect_target  input  32  SHALL be the new PC, valid when redirect=1.
REQ-008 imem_req  output  1  SHALL be the instruction-memory request.
REQ-009 imem_addr  output  32  SHALL be the request address, equal to pc.
REQ-010 imem_gnt  input  1  SHALL be the request accept; handshake completes when imem_req & imem_gnt.
REQ-011 imem_rvalid  input  1  SHALL mark imem_rdata valid, at least 1 cycle after grant.
REQ-012 imem_rdata  input  32  SHALL be the returned instruction word.
REQ-013 instr_valid  output  1  SHALL indicate instr/instr_pc hold a fetched instruction.
REQ-014 instr  output  32  SHALL be the oldest buffered instruction.
REQ-015 instr_pc  output  32  SHALL be the address instr was fetched from.
REQ-016 instr_ready  input  1  SHALL be decode accept; pop when instr_valid & instr_ready.

Function
REQ-017 FSM states IDLE, REQ, WAIT: IDLE->REQ when free slots > 0 and no redirect; REQ->WAIT on grant; WAIT->REQ on rvalid if a slot stays free, else WAIT->IDLE.
REQ-018 At most one request outstanding; imem_req SHALL assert only in REQ.
REQ-019 pc_next SHALL equal pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0) in the grant cycle, redirect_target when redirect=1, else pc.
REQ-020 redirect SHALL take priority over grant for pc_next in the same cycle.
REQ-021 On grant, the granted pc SHALL be latched as the tag for the outstanding response.
REQ-022 On rvalid, {imem_rdata, tag} SHALL be pushed into the instruction buffer; instr_valid rises the next cycle (grant-to-instr_valid latency = memory latency + 1).
REQ-023 Buffer SHALL be FIFO; push and pop in one cycle permitted, including when full.
REQ-024 Free-slot count SHALL count the outstanding request as occupied; no request issued when buffer entries + outstanding = depth; overflow impossible.
REQ-025 redirect SHALL flush the buffer (instr_valid=0 next cycle), return FSM to IDLE, and mark any outstanding or same-cycle-granted response for discard.
REQ-026 A discarded response SHALL be dropped on arrival; no new request issues until it returns.
REQ-027 rvalid coinciding with redirect SHALL be dropped.
REQ-028 A pop coinciding with redirect SHALL be accepted by decode; the buffer is still emptied.
REQ-029 instr, instr_pc SHALL stay stable while instr_valid=1 and instr_ready=0.

Reset
REQ-030 Asserting reset SHALL immediately force FSM=IDLE, buffer empty, discard flag 0, imem_req=0, instr_valid=0, instr=0, instr_pc=0, pc_next=RESET_PC.
REQ-031 Reset mid-operation SHALL abandon outstanding requests; a response arriving after reset release with no request outstanding SHALL be ignored.
REQ-032 The first request SHALL issue no earlier than the second rising edge after reset deassertion.

Configuration
REQ-033 Macro FETCH_SKID_BUF_EN defined: buffer depth 2, allowing back-to-back requests while decode stalls one cycle.
REQ-034 Macro FETCH_SKID_BUF_EN undefined: depth 1; a new request issues only after the held instruction is popped or popped in the same cycle.

Verification
REQ-035 Reset, then gnt tied 1, rvalid 1 cycle after grant, ready=1 -> instr_pc sequence 0x0, 0x4, 0x8; instr equals rdata per address.
REQ-036 pc=0xFFFF_FFFC granted -> pc_next=0x0000_0000 that cycle.
REQ-037 redirect to 0x100 while WAIT on 0x8 -> 0x8 response dropped, next instr_pc=0x100, instr_valid=0 in the cycle after redirect.
REQ-038 instr_ready=0 for 5 cycles -> with macro, 2 entries held then imem_req=0; without, 1 entry then imem_req=0; ordering preserved on release.
REQ-039 redirect and rvalid in same cycle -> no push; pc_next=redirect_target.
REQ-040 reset asserted during WAIT -> all outputs at reset values immediately; late rvalid after release produces no instr_valid.
